nmi_arbiter: RTL
================

# nmi_arbiter

Shares the single Z80 /NMI line between the two NMI requesters in the design: the magic (service ROM) controller and the DivMMC controller. It latches requests, grants one source at a frame boundary, drives `n_nmi`, tracks the handler from the 0x0066 fetch until RETN, and then releases the grant. It sits between the requesters and the CPU pin; requesters use their grant to map their own ROM.

## Interface
Parameters:
- `TIMEOUT_FRAMES`, default 4: INT frames allowed between `n_nmi` assertion and the 0x0066 fetch before the request is aborted.

Ports:
- `rst_n`  in  1  reset, asynchronous, active-low
- `clk28`  in  1  system clock, 28 MHz
- `bus`  cpu_bus  -  snooped CPU bus; uses `mreq`, `m1`, `rd`, `a[15:0]`, `d[7:0]`
- `n_int`  in  1  current /INT level from the timing generator
- `n_int_next`  in  1  /INT level for the next clk28
- `req_magic`  in  1  NMI request from the magic block, sampled as a level
- `req_divmmc`  in  1  NMI request from DivMMC, sampled as a level
- `rel_magic`  in  1  forced release by magic, for example on its ROM unmap
- `rel_divmmc`  in  1  forced release by DivMMC
- `n_nmi`  out  1  CPU /NMI, active-low
- `grant_magic`  out  1  magic owns the current NMI
- `grant_divmmc`  out  1  DivMMC owns the current NMI
- `nmi_src`  out  2  current owner, type `nmi_src_t`
- `timeout`  out  1  one-clk pulse when an assertion is aborted

## Operation
Request latches:
- `pend_m` sets on `req_magic`; `pend_d` sets on `req_divmmc`.
- A pending bit clears only when its source is granted, or on reset.
- A request from the source that currently holds the grant is ignored.

Frame-start strobe:
- `fs = n_int && !n_int_next`.

State machine: IDLE, ASSERT, SERVICE.
- IDLE:
  - on `fs` with any pending bit set, choose the winner; magic has priority over DivMMC.
  - set the winner's grant, clear its pending bit, drive `n_nmi`=0, go to ASSERT.
- ASSERT:
  - on the first clk with `mreq && m1 && a==16'h0066`: `n_nmi`=1, go to SERVICE.
  - each `fs` increments the 3-bit frame counter.
  - when the counter reaches `TIMEOUT_FRAMES`: `n_nmi`=1, grant=0, pulse `timeout`, go to IDLE. The pending bit stays cleared.
- SERVICE:
  - hold the grant until RETN is detected or the owner's `rel_*` is asserted, then grant=0 and go to IDLE.
  - NMI is not re-asserted during SERVICE.

Opcode snoop (RETN detection):
- While `mreq && m1 && rd`, sample `bus.d`.
- On the first clk after that condition drops, evaluate the captured byte as one completed fetch.
- Byte 0xED sets `ed_flag`.
- A completed fetch of 0x45 while `ed_flag` is set means RETN detected.
- Any other completed fetch clears `ed_flag`.
- `ed_flag` clears on entry to SERVICE.
- The detection is ignored outside SERVICE.

`nmi_src` = NMI_MAGIC, NMI_DIVMMC or NMI_NONE, following the grants.

## Timing
- Reset values: `n_nmi`=1, `grant_magic`=0, `grant_divmmc`=0, `nmi_src`=NMI_NONE, `timeout`=0, state IDLE, pending bits 0, `ed_flag`=0, frame counter 0.
- Request to pending: 1 clk.
- Assertion: `n_nmi` and the grant go active on the clk after `fs`, and never mid-frame.
- Acknowledge: `n_nmi` rises on the clk after the first 0x0066 M1 match.
- Release: grant drops 1 clk after the RETN 0x45 fetch completes. A `rel_*` in SERVICE releases on the next clk.
- Simultaneous events:
  - Both requests in one clk: magic is served first and `pend_d` is retained. DivMMC is served at the first `fs` after magic's release.
  - Request in the same clk as release: it is latched and eligible at the next `fs`.
  - `fs` in the same clk as release: not eligible. The first eligible `fs` is the next one.
  - `rel_*` during ASSERT: the owner's release cancels the assertion with `n_nmi`=1 and goes to IDLE, without a `timeout` pulse.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- The counter saturates and never wraps.

## Structure
- Add to `common` package: `typedef enum logic [1:0] {NMI_NONE, NMI_MAGIC, NMI_DIVMMC} nmi_src_t`.
- The state enum is local to the module.
- One sub-module, `retn_snoop`:
  - inputs: clock, reset, bus, enable.
  - output: one-clk `retn` pulse.
  - contains the capture register and `ed_flag`.

## Test plan
- `req_magic` pulse mid-frame → `n_nmi` low only on the clk after the next `fs`; `grant_magic`=1; `nmi_src`=NMI_MAGIC.
- M1 fetch at 0x0066 → `n_nmi`=1 next clk. Then fetches ED, 45 → `grant_magic`=0 one clk after the 45 fetch ends, state IDLE.
- `req_magic` and `req_divmmc` in the same clk → magic served. After RETN, at the next `fs`, `grant_divmmc`=1 and `nmi_src`=NMI_DIVMMC.
- Assert with no 0x0066 fetch for 4 `fs` → `timeout` pulse, `n_nmi`=1, grants 0, magic pending cleared.
- In SERVICE, fetches ED, 00, 45 → no release. Then ED, 45 → release. `rel_divmmc` during DivMMC SERVICE → release next clk.
- `rst_n` low during ASSERT → `n_nmi`=1, grants 0 immediately. After reset, no NMI occurs without a new request.

Source files
------------

// File: rtl/nmi_arbiter_pkg.sv
// ---- nmi_arbiter_pkg: shared types and constants for the /NMI arbiter (rev 1.0) ----
`default_nettype none

package nmi_arbiter_pkg;

    typedef enum logic [1:0] {
        NMI_NONE   = 2'd0,
        NMI_MAGIC  = 2'd1,
        NMI_DIVMMC = 2'd2
    } nmi_src_t;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;
    localparam logic [7:0]  OP_PREFIX_ED = 8'hED;
    localparam logic [7:0]  OP_RETN_2ND  = 8'h45;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'h7) ? v : v + 3'h1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_bus.sv
// ---- cpu_bus: Z80 bus bundle as seen by passive snoopers (rev 1.0) ----
`default_nettype none

interface cpu_bus;
    logic        mreq;
    logic        m1;
    logic        rd;
    logic [15:0] a;
    logic [7:0]  d;

    modport snoop (input mreq, input m1, input rd, input a, input d);
    modport drv   (output mreq, output m1, output rd, output a, output d);
endinterface

`default_nettype wire

// File: rtl/nmi_arbiter_retn.sv
// ---- retn_snoop: watches opcode fetches and pulses retn on a completed ED 45 (rev 1.0) ----
`default_nettype none

module retn_snoop
    import nmi_arbiter_pkg::*;
(
    input  logic      clk28,
    input  logic      rst_n,
    cpu_bus.snoop     bus,
    input  logic      enable,
    output logic      retn
);

    logic       fetch;
    logic       done;
    logic       active_q;
    logic [7:0] cap_q;
    logic       ed_flag_q;
    logic       ed_flag_d;

    assign fetch = bus.mreq & bus.m1 & bus.rd;
    // A fetch is judged once, on the first clock after its strobe window closes.
    assign done  = active_q & ~fetch;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            cap_q     <= 8'h00;
            ed_flag_q <= 1'b0;
        end else begin
            active_q  <= fetch;
            if (fetch) begin
                cap_q <= bus.d;
            end
            ed_flag_q <= ed_flag_d;
        end
    end

    always_comb begin
        ed_flag_d = ed_flag_q;
        if (!enable) begin
            ed_flag_d = 1'b0;
        end else if (done) begin
            ed_flag_d = (cap_q == OP_PREFIX_ED);
        end
    end

    assign retn = enable & done & ed_flag_q & (cap_q == OP_RETN_2ND);

endmodule

`default_nettype wire

// File: rtl/nmi_arbiter.sv
// ---- nmi_arbiter: shares the Z80 /NMI between magic and DivMMC, frame-aligned (rev 1.0) ----
`default_nettype none

module nmi_arbiter
    import nmi_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic     rst_n,
    input  logic     clk28,
    cpu_bus.snoop    bus,
    input  logic     n_int,
    input  logic     n_int_next,
    input  logic     req_magic,
    input  logic     req_divmmc,
    input  logic     rel_magic,
    input  logic     rel_divmmc,
    output logic     n_nmi,
    output logic     grant_magic,
    output logic     grant_divmmc,
    output nmi_src_t nmi_src,
    output logic     timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] TO_LIMIT = 3'(TIMEOUT_FRAMES);

    state_t     state_q,   state_d;
    nmi_src_t   src_q,     src_d;
    logic       n_nmi_q,   n_nmi_d;
    logic       timeout_q, timeout_d;
    logic       pend_m_q,  pend_m_d;
    logic       pend_dv_q, pend_dv_d;
    logic [2:0] cnt_q,     cnt_d;
    logic       take_m;
    logic       take_dv;
    logic       fs;
    logic       ack;
    logic       rel_owner;
    logic       retn;
    logic [2:0] cnt_inc;

    assign fs        = n_int & ~n_int_next;
    assign ack       = bus.mreq & bus.m1 & (bus.a == NMI_VECTOR);
    assign rel_owner = ((src_q == NMI_MAGIC)  & rel_magic) |
                       ((src_q == NMI_DIVMMC) & rel_divmmc);
    assign cnt_inc   = sat_inc3(cnt_q);

    retn_snoop u_retn (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .bus    (bus),
        .enable (state_q == ST_SERVICE),
        .retn   (retn)
    );

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= NMI_NONE;
            n_nmi_q   <= 1'b1;
            timeout_q <= 1'b0;
            pend_m_q  <= 1'b0;
            pend_dv_q <= 1'b0;
            cnt_q     <= 3'h0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            n_nmi_q   <= n_nmi_d;
            timeout_q <= timeout_d;
            pend_m_q  <= pend_m_d;
            pend_dv_q <= pend_dv_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        n_nmi_d   = n_nmi_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        take_m    = 1'b0;
        take_dv   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fs && (pend_m_q || pend_dv_q)) begin
                    if (pend_m_q) begin
                        take_m = 1'b1;
                        src_d  = NMI_MAGIC;
                    end else begin
                        take_dv = 1'b1;
                        src_d   = NMI_DIVMMC;
                    end
                    n_nmi_d = 1'b0;
                    cnt_d   = 3'h0;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (rel_owner) begin
                    n_nmi_d = 1'b1;
                    src_d   = NMI_NONE;
                    state_d = ST_IDLE;
                end else if (ack) begin
                    n_nmi_d = 1'b1;
                    state_d = ST_SERVICE;
                end else if (fs) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIMIT) begin
                        n_nmi_d   = 1'b1;
                        src_d     = NMI_NONE;
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_SERVICE: begin
                if (retn || rel_owner) begin
                    src_d   = NMI_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                src_d   = NMI_NONE;
                n_nmi_d = 1'b1;
            end
        endcase
    end

    // Granting clears a pending bit even if the same source re-requests in that clk.
    always_comb begin
        pend_m_d  = take_m  ? 1'b0 : (pend_m_q  | (req_magic  & (src_q != NMI_MAGIC)));
        pend_dv_d = take_dv ? 1'b0 : (pend_dv_q | (req_divmmc & (src_q != NMI_DIVMMC)));
    end

    assign n_nmi        = n_nmi_q;
    assign timeout      = timeout_q;
    assign nmi_src      = src_q;
    assign grant_magic  = (src_q == NMI_MAGIC);
    assign grant_divmmc = (src_q == NMI_DIVMMC);

endmodule

`default_nettype wire
